vend_ctrl_param: RTL and testbench
==================================

# vend_ctrl_param

Parametrised vending-machine controller, the next generation of the keypad vending FSM. It consumes single-cycle debounced key events and sequences product select, quantity, payment, dispense and change. It adds a per-product stock count, a true price×quantity multiply, a cancel/refund path and an inactivity timeout. It sits between the keypad/debounce front end and the binary2bcd/seven_segment display path.

## Interface
- NUM_PRODUCTS, 5: selectable products, 1..7; key codes 1..NUM_PRODUCTS select.
- PRICE_W, 4: width of each unit price.
- QTY_MAX, 3: maximum quantity per transaction, 1..15.
- AMT_W, 8: width of the entered amount, total, change and display value.
- INIT_STOCK, 4: stock loaded into every product on reset, at most 15.
- TIMEOUT_CYCLES, 1000: idle cycles in SELECT..PAY before auto-cancel.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- key_valid  in  1  one-cycle strobe qualifying key_code.
- key_code  in  4  debounced key: F=OK, E=confirm, C=qty+1, B=cancel, 8/9/A=$1/$5/$10 coin.
- price_table  in  NUM_PRODUCTS*PRICE_W  unit prices; product n sits at bits [n*PRICE_W-1 -: PRICE_W].
- restock  in  1  in IDLE only: reloads every stock counter to INIT_STOCK.
- disp_value  out  AMT_W  value shown on D0..D2.
- disp_state  out  3  state code shown on D3..D5.
- dispense  out  1  one-cycle pulse when the vend commits.
- dispense_id  out  3  selected product, valid with dispense.
- dispense_qty  out  4  quantity, valid with dispense.
- change_amt  out  AMT_W  change or refund, valid with change_valid.
- change_valid  out  1  one-cycle pulse.
- sold_out  out  1  high while the selected product has stock 0.

## Operation
- States and codes: IDLE=0, SELECT=1, PRICE=2, QTY=3, TOTAL=4, PAY=5, DISPENSE=6.
- Only key events with key_valid=1 are acted on. Without a key event, every state holds.
- IDLE: F goes to SELECT. restock is honoured only in IDLE.
- SELECT: key k with 1≤k≤NUM_PRODUCTS and stock[k]>0 latches k, shows its price, and goes to PRICE.
- SELECT, stock[k]=0: sold_out=1 and the state stays SELECT.
- SELECT, k out of range: ignored.
- PRICE: F goes to QTY with qty=1.
- QTY: C increments qty, saturating at min(QTY_MAX, stock[k]). F computes total=price*qty (full-width product, zero-extended/truncated to AMT_W) and goes to TOTAL.
- TOTAL: E clears amount and goes to PAY.
- PAY: coins add 1/5/10 to amount, saturating at 2^AMT_W-1. F with amount≥total goes to DISPENSE. F with amount<total is ignored.
- DISPENSE entry: dispense pulses and stock[k] -= qty. Change behaviour follows Configuration.
- DISPENSE: F returns to IDLE.
- Cancel: B in SELECT..PAY goes to IDLE. change_amt=amount and change_valid pulses if amount>0. Stock is unchanged.
- Timeout: any key event reloads the inactivity counter. If the counter reaches TIMEOUT_CYCLES in SELECT..PAY, the block behaves exactly as for B.
- disp_value per state:
  - IDLE/SELECT: 0.
  - PRICE: price.
  - QTY: qty.
  - TOTAL: total.
  - PAY: amount.
  - DISPENSE: change, or 0.

## Timing
- All outputs are registered. A state change is visible the cycle after the key_valid cycle.
- dispense and change_valid are exactly one cycle wide, asserted in the first DISPENSE cycle or the first IDLE cycle after a cancel.
- Reset values:
  - state=IDLE.
  - All outputs 0.
  - stock[*]=INIT_STOCK.
  - qty=0, amount=0, timeout counter=0.
- Reset mid-transaction drops the amount with no refund pulse.
- A key event in the same cycle as timeout expiry: timeout wins.
- restock outside IDLE is ignored.

## Configuration
- VEND_CHANGE_EN defined: on entry to DISPENSE, change_amt=amount-total and change_valid pulses if the difference is nonzero. disp_value shows the change.
- VEND_CHANGE_EN undefined: any overpayment is kept. change_amt=0 on vend and no change_valid on vend; cancel/timeout refunds still occur. disp_value shows 0 in DISPENSE.

## Test plan
- Product 2 price 10, qty 2 (C once), coins A,A, F -> total 20; dispense with id 2 / qty 2; stock[2] goes 4->2; change 0.
- Product 1 price 6, qty 1, coins A, F:
  - with VEND_CHANGE_EN: change_valid with change_amt=4.
  - without VEND_CHANGE_EN: no change_valid.
- Stock[3] drained to 0, then key 3 in SELECT -> sold_out=1, state stays 1. restock in IDLE then reloads stock[3]=4.
- Coins 9 and 8 in PAY (amount 6), then B -> IDLE, change_valid with change_amt=6, no dispense.
- No keys for TIMEOUT_CYCLES in QTY -> IDLE, no change_valid. Reset asserted in PAY -> all outputs 0 immediately.
- Coins until amount saturates at 255 -> stays 255. F with amount<total -> state stays 5.

Source files
------------

// File: rtl/vend_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : vend_ctrl_param
// Description : Parametrised vending controller: select, quantity, pay,
//               dispense, cancel/refund and inactivity timeout, with stock.
//               Optional feature macro: VEND_CHANGE_EN (returns overpayment).
// Revision    : 1.0 - initial release
// ============================================================================
module vend_ctrl_param #(
    parameter int NUM_PRODUCTS   = 5,
    parameter int PRICE_W        = 4,
    parameter int QTY_MAX        = 3,
    parameter int AMT_W          = 8,
    parameter int INIT_STOCK     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            key_valid,
    input  logic [3:0]                      key_code,
    input  logic [NUM_PRODUCTS*PRICE_W-1:0] price_table,
    input  logic                            restock,
    output logic [AMT_W-1:0]                disp_value,
    output logic [2:0]                      disp_state,
    output logic                            dispense,
    output logic [2:0]                      dispense_id,
    output logic [3:0]                      dispense_qty,
    output logic [AMT_W-1:0]                change_amt,
    output logic                            change_valid,
    output logic                            sold_out
);

    localparam logic [3:0] c_KEY_OK     = 4'hF;
    localparam logic [3:0] c_KEY_CONF   = 4'hE;
    localparam logic [3:0] c_KEY_INC    = 4'hC;
    localparam logic [3:0] c_KEY_CANCEL = 4'hB;
    localparam logic [3:0] c_KEY_C1     = 4'h8;
    localparam logic [3:0] c_KEY_C5     = 4'h9;
    localparam logic [3:0] c_KEY_C10    = 4'hA;
    localparam logic [3:0] c_QTY_MAX    = 4'(QTY_MAX);
    localparam logic [3:0] c_INIT_STOCK = 4'(INIT_STOCK);
    localparam int         c_TMR_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SELECT   = 3'd1,
        S_PRICE    = 3'd2,
        S_QTY      = 3'd3,
        S_TOTAL    = 3'd4,
        S_PAY      = 3'd5,
        S_DISPENSE = 3'd6
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [2:0]             r_sel, w_sel_nxt;
    logic [3:0]             r_qty, w_qty_nxt;
    logic [AMT_W-1:0]       r_total, w_total_nxt;
    logic [AMT_W-1:0]       r_amount, w_amount_nxt;
    logic [AMT_W-1:0]       r_change, w_change_nxt;
    logic [c_TMR_W-1:0]     r_timer, w_timer_nxt;
    logic [3:0]             r_stock [NUM_PRODUCTS];
    logic [3:0]             w_stock_nxt [NUM_PRODUCTS];

    logic [AMT_W-1:0]       w_disp_nxt;
    logic                   w_dispense_nxt;
    logic                   w_change_valid_nxt;
    logic [AMT_W-1:0]       w_change_amt_nxt;
    logic                   w_sold_out_nxt;

    logic [PRICE_W-1:0]     w_price_arr [NUM_PRODUCTS];
    logic [2:0]             w_sel_idx, w_nsel_idx, w_key_idx;
    logic [PRICE_W-1:0]     w_price_sel;
    logic [PRICE_W+3:0]     w_prod;
    logic [3:0]             w_stock_sel, w_qty_lim;
    logic                   w_key_in_range;
    logic                   w_is_coin;
    logic [AMT_W-1:0]       w_coin_val;
    logic [AMT_W:0]         w_amt_sum;
    logic [AMT_W-1:0]       w_amt_sat;
    logic                   w_active, w_active_nxt, w_timeout, w_cancel;
    logic                   w_key_ok;

    for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_price
        assign w_price_arr[g] = price_table[g*PRICE_W +: PRICE_W];
    end

    assign w_sel_idx      = r_sel - 3'd1;
    assign w_nsel_idx     = w_sel_nxt - 3'd1;
    assign w_key_idx      = key_code[2:0] - 3'd1;
    assign w_key_in_range = (key_code != 4'd0) && (key_code <= 4'(NUM_PRODUCTS));
    assign w_price_sel    = w_price_arr[w_sel_idx];
    assign w_prod         = {4'b0, w_price_sel} * {{PRICE_W{1'b0}}, r_qty};
    assign w_stock_sel    = r_stock[w_sel_idx];
    assign w_qty_lim      = (c_QTY_MAX < w_stock_sel) ? c_QTY_MAX : w_stock_sel;
    assign w_key_ok       = key_valid && (key_code == c_KEY_OK);

    always_comb begin
        w_is_coin  = 1'b1;
        w_coin_val = '0;
        case (key_code)
            c_KEY_C1:  w_coin_val = AMT_W'(1);
            c_KEY_C5:  w_coin_val = AMT_W'(5);
            c_KEY_C10: w_coin_val = AMT_W'(10);
            default:   w_is_coin  = 1'b0;
        endcase
    end

    // Amount never wraps: a carry out of the adder pins it at full scale.
    assign w_amt_sum = {1'b0, r_amount} + {1'b0, w_coin_val};
    assign w_amt_sat = w_amt_sum[AMT_W] ? {AMT_W{1'b1}} : w_amt_sum[AMT_W-1:0];

    assign w_active  = (r_state != S_IDLE) && (r_state != S_DISPENSE);
    assign w_timeout = w_active && (r_timer == c_TMR_LAST);
    assign w_cancel  = w_active && (w_timeout || (key_valid && key_code == c_KEY_CANCEL));

    always_comb begin
        w_state_nxt        = r_state;
        w_sel_nxt          = r_sel;
        w_qty_nxt          = r_qty;
        w_total_nxt        = r_total;
        w_amount_nxt       = r_amount;
        w_change_nxt       = r_change;
        w_stock_nxt        = r_stock;
        w_dispense_nxt     = 1'b0;
        w_change_valid_nxt = 1'b0;
        w_change_amt_nxt   = '0;
        w_sold_out_nxt     = sold_out;

        if (w_cancel) begin
            w_state_nxt    = S_IDLE;
            w_qty_nxt      = 4'd0;
            w_amount_nxt   = '0;
            w_change_nxt   = '0;
            w_sold_out_nxt = 1'b0;
            if (r_amount != '0) begin
                w_change_valid_nxt = 1'b1;
                w_change_amt_nxt   = r_amount;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (restock) begin
                        for (int i = 0; i < NUM_PRODUCTS; i++) begin
                            w_stock_nxt[i] = c_INIT_STOCK;
                        end
                    end
                    if (w_key_ok) begin
                        w_state_nxt = S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (key_valid && w_key_in_range) begin
                        if (r_stock[w_key_idx] != 4'd0) begin
                            w_sel_nxt      = key_code[2:0];
                            w_state_nxt    = S_PRICE;
                            w_sold_out_nxt = 1'b0;
                        end else begin
                            w_sold_out_nxt = 1'b1;
                        end
                    end
                end
                S_PRICE: begin
                    if (w_key_ok) begin
                        w_qty_nxt   = 4'd1;
                        w_state_nxt = S_QTY;
                    end
                end
                S_QTY: begin
                    if (key_valid && key_code == c_KEY_INC) begin
                        if (r_qty < w_qty_lim) begin
                            w_qty_nxt = r_qty + 4'd1;
                        end
                    end else if (w_key_ok) begin
                        w_total_nxt = AMT_W'(w_prod);
                        w_state_nxt = S_TOTAL;
                    end
                end
                S_TOTAL: begin
                    if (key_valid && key_code == c_KEY_CONF) begin
                        w_amount_nxt = '0;
                        w_state_nxt  = S_PAY;
                    end
                end
                S_PAY: begin
                    if (key_valid && w_is_coin) begin
                        w_amount_nxt = w_amt_sat;
                    end else if (w_key_ok && (r_amount >= r_total)) begin
                        w_state_nxt               = S_DISPENSE;
                        w_dispense_nxt            = 1'b1;
                        w_stock_nxt[w_sel_idx]    = w_stock_sel - r_qty;
`ifdef VEND_CHANGE_EN
                        w_change_nxt = r_amount - r_total;
                        if (r_amount != r_total) begin
                            w_change_valid_nxt = 1'b1;
                            w_change_amt_nxt   = r_amount - r_total;
                        end
`else
                        w_change_nxt = '0;
`endif
                    end
                end
                S_DISPENSE: begin
                    if (w_key_ok) begin
                        w_state_nxt  = S_IDLE;
                        w_qty_nxt    = 4'd0;
                        w_amount_nxt = '0;
                        w_change_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        // Display follows the state being entered so it lines up with disp_state.
        case (w_state_nxt)
            S_PRICE:    w_disp_nxt = AMT_W'(w_price_arr[w_nsel_idx]);
            S_QTY:      w_disp_nxt = AMT_W'(w_qty_nxt);
            S_TOTAL:    w_disp_nxt = w_total_nxt;
            S_PAY:      w_disp_nxt = w_amount_nxt;
            S_DISPENSE: w_disp_nxt = w_change_nxt;
            default:    w_disp_nxt = '0;
        endcase
    end

    assign w_active_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DISPENSE);

    always_comb begin
        w_timer_nxt = r_timer + c_TMR_W'(1);
        if (key_valid || w_timeout || !w_active_nxt) begin
            w_timer_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_sel        <= 3'd0;
            r_qty        <= 4'd0;
            r_total      <= '0;
            r_amount     <= '0;
            r_change     <= '0;
            r_timer      <= '0;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                r_stock[i] <= c_INIT_STOCK;
            end
            disp_value   <= '0;
            dispense     <= 1'b0;
            dispense_id  <= 3'd0;
            dispense_qty <= 4'd0;
            change_amt   <= '0;
            change_valid <= 1'b0;
            sold_out     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_qty        <= w_qty_nxt;
            r_total      <= w_total_nxt;
            r_amount     <= w_amount_nxt;
            r_change     <= w_change_nxt;
            r_timer      <= w_timer_nxt;
            r_stock      <= w_stock_nxt;
            disp_value   <= w_disp_nxt;
            dispense     <= w_dispense_nxt;
            dispense_id  <= w_dispense_nxt ? r_sel : 3'd0;
            dispense_qty <= w_dispense_nxt ? r_qty : 4'd0;
            change_amt   <= w_change_amt_nxt;
            change_valid <= w_change_valid_nxt;
            sold_out     <= w_sold_out_nxt;
        end
    end

    assign disp_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_ctrl_param
// Description : Directed bench for vend_ctrl_param with a transaction-level
//               reference model checked every cycle. Honours VEND_CHANGE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl_param;

    localparam int NP  = 5;
    localparam int PW  = 4;
    localparam int QM  = 3;
    localparam int AW  = 8;
    localparam int IS  = 4;
    localparam int TMO = 1000;
`ifdef VEND_CHANGE_EN
    localparam bit c_CHANGE_EN = 1'b1;
`else
    localparam bit c_CHANGE_EN = 1'b0;
`endif
    localparam int K_OK = 15, K_CONF = 14, K_INC = 12, K_CANCEL = 11;
    localparam int K_C1 = 8, K_C5 = 9, K_C10 = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          key_valid;
    logic [3:0]    key_code;
    logic [NP*PW-1:0] price_table;
    logic          restock;
    logic [AW-1:0] disp_value;
    logic [2:0]    disp_state;
    logic          dispense;
    logic [2:0]    dispense_id;
    logic [3:0]    dispense_qty;
    logic [AW-1:0] change_amt;
    logic          change_valid;
    logic          sold_out;

    always #5 clk = ~clk;

    vend_ctrl_param #(
        .NUM_PRODUCTS(NP), .PRICE_W(PW), .QTY_MAX(QM), .AMT_W(AW),
        .INIT_STOCK(IS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .price_table(price_table), .restock(restock), .disp_value(disp_value),
        .disp_state(disp_state), .dispense(dispense), .dispense_id(dispense_id),
        .dispense_qty(dispense_qty), .change_amt(change_amt),
        .change_valid(change_valid), .sold_out(sold_out)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: transaction quantities as plain integers.
    int m_state, m_sel, m_qty, m_amount, m_total, m_change, m_idle, m_sold;
    int m_stock [1:NP];
    int m_price [1:NP] = '{6, 10, 3, 7, 15};
    int e_disp, e_id, e_dq, e_chg, e_cv;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit in_txn(input int s);
        return (s >= 1) && (s <= 5);
    endfunction

    task automatic model_reset();
        m_state = 0; m_sel = 0; m_qty = 0; m_amount = 0; m_total = 0;
        m_change = 0; m_idle = 0; m_sold = 0;
        foreach (m_stock[i]) m_stock[i] = IS;
        e_disp = 0; e_id = 0; e_dq = 0; e_chg = 0; e_cv = 0;
    endtask

    task automatic model_step(input bit kv, input int kc, input bit rs);
        int  coin;
        bit  tmo;
        e_disp = 0; e_id = 0; e_dq = 0; e_chg = 0; e_cv = 0;
        tmo  = in_txn(m_state) && (m_idle == TMO - 1);
        coin = (kc == K_C1) ? 1 : (kc == K_C5) ? 5 : (kc == K_C10) ? 10 : 0;
        if (in_txn(m_state) && (tmo || (kv && kc == K_CANCEL))) begin
            if (m_amount > 0) begin
                e_cv  = 1;
                e_chg = m_amount;
            end
            m_state = 0; m_amount = 0; m_qty = 0; m_change = 0; m_sold = 0;
        end else begin
            case (m_state)
                0: begin
                    if (rs) foreach (m_stock[i]) m_stock[i] = IS;
                    if (kv && kc == K_OK) m_state = 1;
                end
                1: if (kv && kc >= 1 && kc <= NP) begin
                    if (m_stock[kc] > 0) begin
                        m_sel = kc; m_sold = 0; m_state = 2;
                    end else begin
                        m_sold = 1;
                    end
                end
                2: if (kv && kc == K_OK) begin
                    m_qty = 1; m_state = 3;
                end
                3: if (kv && kc == K_INC) begin
                    m_qty = imin(m_qty + 1, imin(QM, m_stock[m_sel]));
                end else if (kv && kc == K_OK) begin
                    m_total = (m_price[m_sel] * m_qty) % (1 << AW);
                    m_state = 4;
                end
                4: if (kv && kc == K_CONF) begin
                    m_amount = 0; m_state = 5;
                end
                5: if (kv && coin > 0) begin
                    m_amount = imin(m_amount + coin, (1 << AW) - 1);
                end else if (kv && kc == K_OK && m_amount >= m_total) begin
                    e_disp = 1; e_id = m_sel; e_dq = m_qty;
                    m_stock[m_sel] = m_stock[m_sel] - m_qty;
                    m_state  = 6;
                    m_change = c_CHANGE_EN ? (m_amount - m_total) : 0;
                    if (m_change != 0) begin
                        e_cv = 1; e_chg = m_change;
                    end
                end
                6: if (kv && kc == K_OK) begin
                    m_state = 0; m_amount = 0; m_qty = 0; m_change = 0;
                end
                default: m_state = 0;
            endcase
        end
        m_idle = (kv || !in_txn(m_state)) ? 0 : m_idle + 1;
    endtask

    function automatic int model_disp();
        case (m_state)
            2:       return m_price[m_sel];
            3:       return m_qty;
            4:       return m_total;
            5:       return m_amount;
            6:       return m_change;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at the falling edge, check the model just after the rising edge.
    task automatic tick(input bit kv, input int kc, input bit rs);
        logic [28:0] act, exp;
        @(negedge clk);
        key_valid = kv;
        key_code  = 4'(kc);
        restock   = rs;
        model_step(kv, kc, rs);
        @(posedge clk);
        #1;
        act = {disp_value, disp_state, dispense, dispense_id, dispense_qty,
               change_amt, change_valid, sold_out};
        exp = {8'(model_disp()), 3'(m_state), 1'(e_disp), 3'(e_id), 4'(e_dq),
               8'(e_chg), 1'(e_cv), 1'(m_sold)};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL cycle_model t=%0t: got %h, expected %h", $time, act, exp);
        end
        #1;
    endtask

    task automatic key(input int k);
        tick(1'b1, k, 1'b0);
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        key_valid = 1'b0; key_code = 4'd0; restock = 1'b0;
        model_reset();
        #1;
        check("rst_state", int'(disp_state), 0);
        check("rst_disp", int'(disp_value), 0);
        check("rst_pulses", int'({dispense, change_valid, sold_out}), 0);
        check("rst_chg_id", int'({change_amt, dispense_id, dispense_qty}), 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int  n;
        bit  saw_cv;
        price_table = 20'hF73A6;
        hold_reset();

        // Product 2 at 10, qty 2, paid exactly.
        key(K_OK); key(2);
        check("p2_price", int'(disp_value), 10);
        key(K_OK); key(K_INC); key(K_OK);
        check("p2_total", int'(disp_value), 20);
        key(K_CONF); key(K_C10); key(K_C10); key(K_OK);
        check("p2_dispense", int'(dispense), 1);
        check("p2_id", int'(dispense_id), 2);
        check("p2_qty", int'(dispense_qty), 2);
        check("p2_no_change", int'(change_valid), 0);
        key(K_OK);
        // Stock[2] is now 2, so quantity tops out at 2.
        key(K_OK); key(2); key(K_OK); key(K_INC); key(K_INC); key(K_INC);
        check("p2_qty_stock_cap", int'(disp_value), 2);
        key(K_CANCEL);

        // Product 1 at 6, paid with 10.
        key(K_OK); key(1); key(K_OK); key(K_OK); key(K_CONF); key(K_C10); key(K_OK);
`ifdef VEND_CHANGE_EN
        check("p1_change_valid", int'(change_valid), 1);
        check("p1_change_amt", int'(change_amt), 4);
`else
        check("p1_change_valid", int'(change_valid), 0);
        check("p1_change_disp", int'(disp_value), 0);
`endif
        key(K_OK);

        // Drain product 3, then sold-out and restock.
        key(K_OK); key(3); key(K_OK); key(K_INC); key(K_INC); key(K_OK);
        key(K_CONF); key(K_C10); key(K_OK); key(K_OK);
        key(K_OK); key(3); key(K_OK); key(K_OK); key(K_CONF); key(K_C5); key(K_OK); key(K_OK);
        key(K_OK); key(3);
        check("p3_sold_out", int'(sold_out), 1);
        check("p3_stays_select", int'(disp_state), 1);
        key(K_CANCEL);
        tick(1'b0, 0, 1'b1);
        key(K_OK); key(3);
        check("p3_restocked", int'(disp_state), 2);
        key(K_OK); key(K_INC); key(K_INC); key(K_INC);
        check("p3_qty_max", int'(disp_value), 3);
        key(K_CANCEL);

        // Cancel in PAY refunds the amount.
        key(K_OK); key(1); key(K_OK); key(K_OK); key(K_CONF); key(K_C5); key(K_C1);
        check("cancel_amount", int'(disp_value), 6);
        key(K_CANCEL);
        check("cancel_cv", int'(change_valid), 1);
        check("cancel_amt", int'(change_amt), 6);
        check("cancel_no_disp", int'(dispense), 0);
        check("cancel_idle", int'(disp_state), 0);

        // Inactivity timeout in QTY.
        key(K_OK); key(1); key(K_OK);
        n = 0; saw_cv = 1'b0;
        while (n < TMO + 100 && disp_state != 3'd0) begin
            tick(1'b0, 0, 1'b0);
            n++;
            if (change_valid) saw_cv = 1'b1;
        end
        check("timeout_cycles", n, TMO);
        check("timeout_no_refund", int'(saw_cv), 0);

        // Amount saturation, then underpaid OK.
        key(K_OK); key(1); key(K_OK); key(K_OK); key(K_CONF);
        for (int i = 0; i < 26; i++) key(K_C10);
        check("amount_sat", int'(disp_value), 255);
        key(K_C1);
        check("amount_sat_hold", int'(disp_value), 255);
        key(K_CANCEL);
        check("sat_refund", int'(change_amt), 255);
        key(K_OK); key(2); key(K_OK); key(K_INC); key(K_OK); key(K_CONF); key(K_C5); key(K_OK);
        check("underpay_stays_pay", int'(disp_state), 5);
        check("underpay_no_disp", int'(dispense), 0);

        // Reset mid-transaction: everything clears at once, no refund afterwards.
        hold_reset();
        tick(1'b0, 0, 1'b0);
        check("post_rst_no_refund", int'(change_valid), 0);
        key(K_OK); key(2); key(K_OK); key(K_INC); key(K_INC);
        check("post_rst_stock", int'(disp_value), 3);
        key(K_CANCEL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
